autoplay_seq: RTL and testbench

Attract-mode autoplay sequencer for the cabinet input lines. After reset it waits, inserts a coin, presses start, then throws periodically, driving the same active-low coin/start/throw lines the player drives. It sits between the input debouncers and the game's switch inputs in the pixel-clock domain. It arbitrates the lines: any player activity immediately hands control to the player, and autoplay resumes after a period of inactivity.

---
 rtl/autoplay_seq.sv | 151 +++++++++++++++
 tb/tb_autoplay_seq.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/autoplay_seq.sv
`default_nettype none
// ============================================================================
// Module   : autoplay_seq
// Purpose  : Attract-mode autoplay for the coin/start/throw lines. Releases the
//            lines to the player whenever the player is active or autoplay is
//            disabled.
// Options  : AUTOPLAY_LOOP_EN - restart the attract sequence after PLAY_CYC
//            cycles of PLAY instead of staying in PLAY.
// Revision : 1.0 - initial release
// ============================================================================
module autoplay_seq #(
  parameter logic [31:0] WAIT_CYC     = 32'd1000,
  parameter logic [31:0] PULSE_CYC    = 32'd100,
  parameter logic [31:0] GAP_CYC      = 32'd500,
  parameter logic [31:0] THROW_PERIOD = 32'd2000,
  parameter logic [31:0] IDLE_TIMEOUT = 32'd50000,
  parameter logic [31:0] PLAY_CYC     = 32'd1000000
) (
  input  logic       clk_pix,
  input  logic       reset,
  input  logic       enable,
  input  logic       player_coin_n,
  input  logic       player_start_n,
  input  logic       player_throw_n,
  output logic       coin_n,
  output logic       start_n,
  output logic       throw_n,
  output logic       autoplay_active,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_WAIT   = 3'd0,
    S_COIN   = 3'd1,
    S_GAP1   = 3'd2,
    S_START  = 3'd3,
    S_GAP2   = 3'd4,
    S_PLAY   = 3'd5,
    S_MANUAL = 3'd6
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_cnt;
  logic [31:0] r_tcnt;
  logic        r_coin_n;
  logic        r_start_n;
  logic        r_throw_n;
  logic        r_active;

  logic        w_player_act;
  logic        w_abort;
  logic        w_play_expire;
  logic        w_auto_coin;
  logic        w_auto_start;
  logic        w_auto_throw;

  assign w_player_act = ~player_coin_n | ~player_start_n | ~player_throw_n;
  assign w_abort      = w_player_act | ~enable;

`ifdef AUTOPLAY_LOOP_EN
  assign w_play_expire = (r_cnt == PLAY_CYC - 32'd1);
`else
  // PLAY never times out; the compare stays so PLAY_CYC remains referenced.
  assign w_play_expire = 1'b0 & (r_cnt == PLAY_CYC - 32'd1);
`endif

  // Auto drives are gated by w_abort so the line is released on the same
  // edge that hands control to the player.
  always_comb begin
    w_state_nxt  = r_state;
    w_auto_coin  = 1'b0;
    w_auto_start = 1'b0;
    w_auto_throw = 1'b0;
    case (r_state)
      S_WAIT: begin
        if (w_abort)                            w_state_nxt = S_MANUAL;
        else if (r_cnt == WAIT_CYC - 32'd1)     w_state_nxt = S_COIN;
      end
      S_COIN: begin
        w_auto_coin = ~w_abort;
        if (w_abort)                            w_state_nxt = S_MANUAL;
        else if (r_cnt == PULSE_CYC - 32'd1)    w_state_nxt = S_GAP1;
      end
      S_GAP1: begin
        if (w_abort)                            w_state_nxt = S_MANUAL;
        else if (r_cnt == GAP_CYC - 32'd1)      w_state_nxt = S_START;
      end
      S_START: begin
        w_auto_start = ~w_abort;
        if (w_abort)                            w_state_nxt = S_MANUAL;
        else if (r_cnt == PULSE_CYC - 32'd1)    w_state_nxt = S_GAP2;
      end
      S_GAP2: begin
        if (w_abort)                            w_state_nxt = S_MANUAL;
        else if (r_cnt == GAP_CYC - 32'd1)      w_state_nxt = S_PLAY;
      end
      S_PLAY: begin
        w_auto_throw = ~w_abort & (r_tcnt < PULSE_CYC);
        if (w_abort)                            w_state_nxt = S_MANUAL;
        else if (w_play_expire)                 w_state_nxt = S_WAIT;
      end
      S_MANUAL: begin
        if (!w_abort && (r_cnt == IDLE_TIMEOUT - 32'd1)) w_state_nxt = S_WAIT;
      end
      default: begin
        w_state_nxt = S_WAIT;
      end
    endcase
  end

  always_ff @(posedge clk_pix) begin
    if (reset) begin
      r_state   <= S_WAIT;
      r_cnt     <= '0;
      r_tcnt    <= '0;
      r_coin_n  <= 1'b1;
      r_start_n <= 1'b1;
      r_throw_n <= 1'b1;
      r_active  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;

      if (w_state_nxt != r_state)
        r_cnt <= '0;
      else if ((r_state == S_MANUAL) && w_abort)
        r_cnt <= '0;
      else
        r_cnt <= r_cnt + 32'd1;

      // tcnt starts at 0 on PLAY entry so the first throw begins immediately.
      if ((r_state == S_PLAY) && (w_state_nxt == S_PLAY))
        r_tcnt <= (r_tcnt == THROW_PERIOD - 32'd1) ? 32'd0 : r_tcnt + 32'd1;
      else
        r_tcnt <= '0;

      r_coin_n  <= player_coin_n  & ~w_auto_coin;
      r_start_n <= player_start_n & ~w_auto_start;
      r_throw_n <= player_throw_n & ~w_auto_throw;
      r_active  <= (w_state_nxt != S_MANUAL);
    end
  end

  assign coin_n          = r_coin_n;
  assign start_n         = r_start_n;
  assign throw_n         = r_throw_n;
  assign autoplay_active = r_active;
  assign state           = r_state;

endmodule
`default_nettype wire

// File: tb/tb_autoplay_seq.sv
`default_nettype none
// Testbench for autoplay_seq: timeline-based reference model compared every
// cycle, directed scenarios with literal expectations, then random stimulus.
module tb_autoplay_seq;

  localparam int W        = 10;
  localparam int P        = 3;
  localparam int G        = 5;
  localparam int PER      = 8;
  localparam int IDLE     = 20;
  localparam int PLAYC    = 40;
  localparam int PLAY_OFF = W + 2*P + 2*G;
  localparam int L        = PLAY_OFF + PLAYC;

  logic       clk_pix = 1'b0;
  logic       reset   = 1'b1;
  logic       enable  = 1'b1;
  logic       pc      = 1'b1;
  logic       ps      = 1'b1;
  logic       pt      = 1'b1;
  logic       coin_n;
  logic       start_n;
  logic       throw_n;
  logic       autoplay_active;
  logic [2:0] state;

  int n_checks = 0;
  int n_fail   = 0;
  int t        = 0;

  autoplay_seq #(
    .WAIT_CYC    (32'd10),
    .PULSE_CYC   (32'd3),
    .GAP_CYC     (32'd5),
    .THROW_PERIOD(32'd8),
    .IDLE_TIMEOUT(32'd20),
    .PLAY_CYC    (32'd40)
  ) dut (
    .clk_pix        (clk_pix),
    .reset          (reset),
    .enable         (enable),
    .player_coin_n  (pc),
    .player_start_n (ps),
    .player_throw_n (pt),
    .coin_n         (coin_n),
    .start_n        (start_n),
    .throw_n        (throw_n),
    .autoplay_active(autoplay_active),
    .state          (state)
  );

  always #5 clk_pix = ~clk_pix;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0d, time %0t)", name, act, exp, t, $time);
    end
  endtask

  // Attract sequence position as a function of cycles since WAIT was entered.
  function automatic int phase_state(input int off_in);
    int off;
    off = off_in;
`ifdef AUTOPLAY_LOOP_EN
    off = off % L;
`endif
    if (off < W)         return 0;
    if (off < W + P)     return 1;
    if (off < W + P + G) return 2;
    if (off < W + 2*P + G) return 3;
    if (off < PLAY_OFF)  return 4;
    return 5;
  endfunction

  function automatic bit throw_low(input int off_in);
    int off;
    off = off_in;
`ifdef AUTOPLAY_LOOP_EN
    off = off % L;
`endif
    return (phase_state(off) == 5) && (((off - PLAY_OFF) % PER) < P);
  endfunction

  // Reference model: auto mode tracks the edge at which WAIT began, manual
  // mode tracks the run of quiet enabled cycles.
  bit         m_valid = 1'b0;
  bit         m_auto  = 1'b1;
  int         m_t0    = 0;
  int         m_idle  = 0;
  int         m_n     = 0;
  bit         s_rst, s_en, s_pc, s_ps, s_pt, abort;
  int         pre;
  logic [2:0] e_state;
  logic       e_c, e_s, e_t, e_a;

  initial begin
    forever begin
      @(posedge clk_pix);
      s_rst = reset; s_en = enable; s_pc = pc; s_ps = ps; s_pt = pt;
      m_n++;
      #1;
      if (s_rst) begin
        m_valid = 1'b1;
        m_auto  = 1'b1;
        m_t0    = m_n;
        e_state = 3'd0; e_c = 1'b1; e_s = 1'b1; e_t = 1'b1; e_a = 1'b1;
      end else if (m_valid) begin
        abort = !s_pc || !s_ps || !s_pt || !s_en;
        pre   = m_auto ? phase_state(m_n - 1 - m_t0) : 6;
        e_c = s_pc & ~(m_auto && !abort && pre == 1);
        e_s = s_ps & ~(m_auto && !abort && pre == 3);
        e_t = s_pt & ~(m_auto && !abort && throw_low(m_n - 1 - m_t0));
        if (m_auto) begin
          if (abort) begin m_auto = 1'b0; m_idle = 0; end
        end else if (abort) begin
          m_idle = 0;
        end else if (m_idle == IDLE - 1) begin
          m_auto = 1'b1; m_t0 = m_n;
        end else begin
          m_idle++;
        end
        e_state = m_auto ? 3'(phase_state(m_n - m_t0)) : 3'd6;
        e_a     = m_auto;
      end
      if (m_valid) begin
        n_checks++;
        if ({state, coin_n, start_n, throw_n, autoplay_active} !== {e_state, e_c, e_s, e_t, e_a}) begin
          n_fail++;
          $display("FAIL per-cycle outputs at edge %0d: got st=%0d c=%b s=%b t=%b a=%b, expected st=%0d c=%b s=%b t=%b a=%b",
                   m_n, state, coin_n, start_n, throw_n, autoplay_active, e_state, e_c, e_s, e_t, e_a);
        end
      end
    end
  end

  task automatic go_to(input int k);
    while (t < k) begin
      @(negedge clk_pix);
      t++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk_pix);
    reset = 1'b1; pc = 1'b1; ps = 1'b1; pt = 1'b1; enable = 1'b1;
    repeat (2) @(negedge clk_pix);
    check("reset state", int'(state), 0);
    check("reset outputs", int'({coin_n, start_n, throw_n}), 7);
    check("reset active", int'(autoplay_active), 1);
    reset = 1'b0;
    t = 0;
  endtask

  initial begin
    // Model pins
    check("model phase at W", phase_state(W), 1);
    check("model phase at W+P", phase_state(W + P), 2);
    check("model phase at PLAY", phase_state(PLAY_OFF), 5);
    check("model throw at PLAY+P", int'(throw_low(PLAY_OFF + P)), 0);

    // Idle attract sequence
    do_reset();
    go_to(10); check("coin before pulse", int'(coin_n), 1);
    go_to(11); check("coin first low", int'(coin_n), 0); check("state COIN", int'(state), 1);
    go_to(13); check("coin last low", int'(coin_n), 0);
    go_to(14); check("coin released", int'(coin_n), 1);
    go_to(19); check("start first low", int'(start_n), 0);
    go_to(22); check("start released", int'(start_n), 1);
    go_to(27); check("throw first low", int'(throw_n), 0); check("state PLAY", int'(state), 5);
    go_to(30); check("throw released", int'(throw_n), 1);
    go_to(35); check("throw second low", int'(throw_n), 0);

    // Player throw during PLAY
    go_to(40); pt = 1'b0;
    go_to(41); pt = 1'b1;
    check("manual after throw", int'(state), 6);
    check("throw mirrors player", int'(throw_n), 0);
    check("active low in manual", int'(autoplay_active), 0);
    go_to(42); check("throw follows player high", int'(throw_n), 1);
    go_to(60); check("still manual", int'(state), 6);
    go_to(61); check("resume WAIT", int'(state), 0);
    go_to(72); check("coin after resume", int'(coin_n), 0);

    // enable=0 during coin pulse
    go_to(73); enable = 1'b0;
    go_to(74); check("coin released by disable", int'(coin_n), 1); check("disable -> manual", int'(state), 6);
    go_to(120); check("held manual while disabled", int'(state), 6);
    enable = 1'b1;
    go_to(150);

    // Player coin on GAP1 expiry
    do_reset();
    go_to(17); pc = 1'b0;
    go_to(18); pc = 1'b1;
    check("manual not START", int'(state), 6);
    check("coin mirrors player", int'(coin_n), 0);
    go_to(22); check("start never pulses", int'(start_n), 1);

    // Reset mid-START
    do_reset();
    go_to(19); reset = 1'b1;
    go_to(20); reset = 1'b0;
    check("start released by reset", int'(start_n), 1);
    check("state WAIT after reset", int'(state), 0);
    t = 0;
    go_to(11); check("coin after mid-pulse reset", int'(coin_n), 0);

`ifdef AUTOPLAY_LOOP_EN
    go_to(65); check("PLAY before loop", int'(state), 5);
    go_to(66); check("loop back to WAIT", int'(state), 0);
    go_to(77); check("second coin pulse", int'(coin_n), 0);
`else
    go_to(250); check("PLAY persists", int'(state), 5);
    check("active in PLAY", int'(autoplay_active), 1);
`endif

    // Random stimulus
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk_pix);
      pc = ($urandom_range(0, 149) != 0);
      ps = ($urandom_range(0, 149) != 0);
      pt = ($urandom_range(0, 149) != 0);
      if ($urandom_range(0, 299) == 0) enable = ~enable;
      reset = ($urandom_range(0, 999) == 0);
    end
    @(negedge clk_pix);
    reset = 1'b0; pc = 1'b1; ps = 1'b1; pt = 1'b1; enable = 1'b1;
    repeat (5) @(negedge clk_pix);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
